// File: rtl/wb_efuse_arbiter.sv
// wb_efuse_arbiter
//   Two-master Wishbone arbiter in front of the eFuse Wishbone switch.
//   m0 is the caravel bus and m1 is the on-chip fuse loader. The grant is
//   round-robin and is held for a whole CYC burst. A per-transfer watchdog
//   ends any transfer the slave never ACKs, so a dead eFuse block cannot
//   hang either master.
// Ports
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   m0_* / m1_*                Wishbone master-side ports
//                              (adr/dat/we/sel/stb/cyc in, dat/ack out)
//   wbs_*                      master port towards the eFuse switch
//   grant_o                    one-hot current owner {m1,m0}, 2'b00 = idle
//   timeout_o                  one-cycle pulse when a transfer is aborted
module wb_efuse_arbiter #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [63:0] TIMEOUT_DATA   = 64'h0000_0000_DEAD_BEEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_cyc_o,
  input  logic                    wbs_ack_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  // A zero-cycle timeout disables the watchdog; keep the counter at least 1 bit.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [DATA_WIDTH-1:0] ABORT_DATA = TIMEOUT_DATA[DATA_WIDTH-1:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             last_owner_r;   // also names the aborted master while in ABORT
  logic             owner_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             own_stb_s;
  logic             wd_hit_s;

  // One-hot grant for a given state/owner pair.
  function automatic logic [1:0] grant_of(input state_t st, input logic owner);
    logic [1:0] g;
    case (st)
      ST_OWN0:  g = 2'b01;
      ST_OWN1:  g = 2'b10;
      ST_ABORT: g = owner ? 2'b10 : 2'b01;
      default:  g = 2'b00;
    endcase
    return g;
  endfunction

  // Strobe of the current owner and the watchdog expiry condition.
  always_comb begin
    case (state_r)
      ST_OWN0: own_stb_s = m0_stb_i;
      ST_OWN1: own_stb_s = m1_stb_i;
      default: own_stb_s = 1'b0;
    endcase
    wd_hit_s = WD_EN && own_stb_s && !wbs_ack_i && (cnt_r == CNT_LAST);
  end

  // Next-state and next-owner logic; a release hands over directly with no IDLE bubble.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = last_owner_r;
    case (state_r)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_owner_r) begin
            state_nxt_s = ST_OWN0;
            owner_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_OWN1;
            owner_nxt_s = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_nxt_s = ST_OWN0;
          owner_nxt_s = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt_s = ST_OWN1;
          owner_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          if (m1_cyc_i) begin
            state_nxt_s = ST_OWN1;
            owner_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (wd_hit_s) begin
          state_nxt_s = ST_ABORT;
        end else begin
          state_nxt_s = ST_OWN0;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          if (m0_cyc_i) begin
            state_nxt_s = ST_OWN0;
            owner_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (wd_hit_s) begin
          state_nxt_s = ST_ABORT;
        end else begin
          state_nxt_s = ST_OWN1;
        end
      end
      ST_ABORT: begin
        if (last_owner_r ? m1_cyc_i : m0_cyc_i) begin
          state_nxt_s = last_owner_r ? ST_OWN1 : ST_OWN0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, owner, watchdog counter and registered status outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r      <= ST_IDLE;
      last_owner_r <= 1'b1;
      cnt_r        <= '0;
      grant_o      <= 2'b00;
      timeout_o    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_owner_r <= owner_nxt_s;
      if (!WD_EN || (state_nxt_s != state_r) || wbs_ack_i || !own_stb_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
      grant_o   <= grant_of(state_nxt_s, owner_nxt_s);
      timeout_o <= (state_nxt_s == ST_ABORT);
    end
  end

  // Bus steering: owner passes straight through; ACK is gated by the owner's CYC.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    m0_ack_o  = 1'b0;
    m0_dat_o  = '0;
    m1_ack_o  = 1'b0;
    m1_dat_o  = '0;
    case (state_r)
      ST_OWN0: begin
        wbs_adr_o = m0_adr_i;
        wbs_dat_o = m0_dat_i;
        wbs_we_o  = m0_we_i;
        wbs_sel_o = m0_sel_i;
        wbs_stb_o = m0_stb_i;
        wbs_cyc_o = m0_cyc_i;
        m0_ack_o  = wbs_ack_i & m0_cyc_i;
        m0_dat_o  = wbs_dat_i;
      end
      ST_OWN1: begin
        wbs_adr_o = m1_adr_i;
        wbs_dat_o = m1_dat_i;
        wbs_we_o  = m1_we_i;
        wbs_sel_o = m1_sel_i;
        wbs_stb_o = m1_stb_i;
        wbs_cyc_o = m1_cyc_i;
        m1_ack_o  = wbs_ack_i & m1_cyc_i;
        m1_dat_o  = wbs_dat_i;
      end
      ST_ABORT: begin
        // Slave is cut off; a late wbs_ack_i is not forwarded.
        if (last_owner_r) begin
          m1_ack_o = 1'b1;
          m1_dat_o = ABORT_DATA;
        end else begin
          m0_ack_o = 1'b1;
          m0_dat_o = ABORT_DATA;
        end
      end
      default: begin
        wbs_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_efuse_arbiter.sv
// Directed testbench for wb_efuse_arbiter. u_dut uses an 8-cycle watchdog;
// u_dut_nowd shares every input but has the watchdog disabled.
module tb_wb_efuse_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_dat, m1_dat;
  logic          m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
  logic [SW-1:0] m0_sel, m1_sel;
  logic [DW-1:0] s_dat;
  logic          s_ack;

  logic [DW-1:0] m0_rdat, m1_rdat, wbs_adr, wbs_wdat;
  logic          m0_ack, m1_ack, wbs_we, wbs_stb, wbs_cyc, tmo;
  logic [SW-1:0] wbs_sel;
  logic [1:0]    grant;

  logic [DW-1:0] n_m0_rdat, n_m1_rdat, n_wbs_adr, n_wbs_wdat;
  logic          n_m0_ack, n_m1_ack, n_wbs_we, n_wbs_stb, n_wbs_cyc, n_tmo;
  logic [SW-1:0] n_wbs_sel;
  logic [1:0]    n_grant;

  wb_efuse_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) u_dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack),
    .wbs_adr_o(wbs_adr), .wbs_dat_o(wbs_wdat), .wbs_dat_i(s_dat), .wbs_we_o(wbs_we),
    .wbs_sel_o(wbs_sel), .wbs_stb_o(wbs_stb), .wbs_cyc_o(wbs_cyc), .wbs_ack_i(s_ack),
    .grant_o(grant), .timeout_o(tmo)
  );

  wb_efuse_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(0)) u_dut_nowd (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(n_m0_rdat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(n_m0_ack),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(n_m1_rdat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(n_m1_ack),
    .wbs_adr_o(n_wbs_adr), .wbs_dat_o(n_wbs_wdat), .wbs_dat_i(s_dat), .wbs_we_o(n_wbs_we),
    .wbs_sel_o(n_wbs_sel), .wbs_stb_o(n_wbs_stb), .wbs_cyc_o(n_wbs_cyc), .wbs_ack_i(s_ack),
    .grant_o(n_grant), .timeout_o(n_tmo)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int nowd_bad;
  int wd8_aborts;

  initial begin
    m0_adr = '0; m0_dat = '0; m0_we = 1'b0; m0_sel = 4'hF; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_we = 1'b0; m1_sel = 4'hF; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_dat = '0; s_ack = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_grant", grant, 2'b00);
    chk("rst_wbs_cyc", wbs_cyc, 1'b0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m0_dat", m0_rdat, 32'h0);
    chk("rst_timeout", tmo, 1'b0);
    rst_n = 1'b1;

    // Single m0 read, slave acks at t3
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_1000;
    @(negedge clk);
    chk("rd_t0_grant", grant, 2'b00);
    chk("rd_t0_cyc", wbs_cyc, 1'b0);
    step();
    @(negedge clk);
    chk("rd_t1_grant", grant, 2'b01);
    chk("rd_t1_cyc", wbs_cyc, 1'b1);
    chk("rd_t1_adr", wbs_adr, 32'h0000_1000);
    chk("rd_t1_ack", m0_ack, 1'b0);
    step();
    step();
    s_ack = 1'b1; s_dat = 32'h1234_5678;
    @(negedge clk);
    chk("rd_t3_ack", m0_ack, 1'b1);
    chk("rd_t3_dat", m0_rdat, 32'h1234_5678);
    chk("rd_t3_m1_ack", m1_ack, 1'b0);
    chk("rd_t3_m1_dat", m1_rdat, 32'h0);
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    chk("rd_t4_ack", m0_ack, 1'b0);
    step();
    @(negedge clk);
    chk("rd_t5_grant", grant, 2'b00);

    // Tie after reset: m0 first, handoff to m1 with no idle cycle
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
    m0_cyc = 1'b1; m1_cyc = 1'b1; m0_adr = 32'h0000_00A0; m1_adr = 32'h0000_00B0;
    step();
    s_ack = 1'b1;
    @(negedge clk);
    chk("tie_grant_m0", grant, 2'b01);
    chk("tie_adr_m0", wbs_adr, 32'h0000_00A0);
    chk("tie_m0_ack", m0_ack, 1'b1);
    chk("tie_m1_ack", m1_ack, 1'b0);
    step();
    s_ack = 1'b0; m0_cyc = 1'b0;
    @(negedge clk);
    chk("tie_hold", grant, 2'b01);
    step();
    @(negedge clk);
    chk("handoff_grant", grant, 2'b10);
    chk("handoff_adr", wbs_adr, 32'h0000_00B0);
    step();
    m1_cyc = 1'b0;
    step();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    @(negedge clk);
    chk("rr_idle", grant, 2'b00);
    step();
    @(negedge clk);
    chk("rr_m0_after_m1", grant, 2'b01);
    step();
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    step();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    step();
    @(negedge clk);
    chk("rr_m1_after_m0", grant, 2'b10);

    // m1 burst of 4 writes while m0 waits
    step();
    m0_stb = 1'b1; m0_adr = 32'h0000_2000;
    m1_stb = 1'b1; m1_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m1_adr = 32'h0000_0100 + 32'(4 * k);
      m1_dat = 32'hA000_0000 + 32'(k);
      s_ack = 1'b1;
      @(negedge clk);
      chk("burst_grant", grant, 2'b10);
      chk("burst_we", wbs_we, 1'b1);
      chk("burst_dat", wbs_wdat, 32'hA000_0000 + 32'(k));
      chk("burst_adr", wbs_adr, 32'h0000_0100 + 32'(4 * k));
      chk("burst_m1_ack", m1_ack, 1'b1);
      chk("burst_m0_ack", m0_ack, 1'b0);
      step();
    end
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    @(negedge clk);
    chk("burst_end_m0_ack", m0_ack, 1'b0);
    step();
    @(negedge clk);
    chk("m0_after_burst", grant, 2'b01);
    chk("m0_after_burst_adr", wbs_adr, 32'h0000_2000);
    chk("m0_after_burst_stb", wbs_stb, 1'b1);

    // Watchdog: 8 unacked cycles then one ABORT cycle
    for (int i = 1; i < 8; i++) begin
      step();
      @(negedge clk);
      chk("wd_wait_ack", m0_ack, 1'b0);
      chk("wd_wait_tmo", tmo, 1'b0);
    end
    step();
    s_ack = 1'b1; s_dat = 32'h5555_5555;
    @(negedge clk);
    chk("abort_tmo", tmo, 1'b1);
    chk("abort_ack", m0_ack, 1'b1);
    chk("abort_dat", m0_rdat, 32'hDEAD_BEEF);
    chk("abort_cyc", wbs_cyc, 1'b0);
    chk("abort_stb", wbs_stb, 1'b0);
    chk("abort_m1_ack", m1_ack, 1'b0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    @(negedge clk);
    chk("post_abort_tmo", tmo, 1'b0);
    chk("late_ack_m0", m0_ack, 1'b0);
    chk("late_ack_m1", m1_ack, 1'b0);
    chk("post_abort_grant", grant, 2'b00);
    s_ack = 1'b0;

    // Reset mid-transfer, then m1 alone
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    @(negedge clk);
    chk("pre_rst_grant", grant, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc", wbs_cyc, 1'b0);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_ack", m0_ack, 1'b0);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b1;
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_m1", grant, 2'b10);

    // Watchdog disabled: 1000 silent cycles, transfer stays pending
    step();
    m1_cyc = 1'b0;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    nowd_bad = 0;
    wd8_aborts = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (n_tmo || n_m0_ack) nowd_bad++;
      if (tmo) wd8_aborts++;
    end
    chk("nowd_no_abort", 64'(nowd_bad), 64'd0);
    chk("nowd_grant", n_grant, 2'b01);
    chk("nowd_stb", n_wbs_stb, 1'b1);
    chk("wd8_abort_count", 64'(wd8_aborts), 64'd111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
